// File: rtl/mw_stage.sv
// M->W pipeline stage: two-entry in-order skid buffer carrying the full
// instruction payload. in_ready depends on state only, breaking the ready path.
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no instruction held, head outputs read zero
// ONE   | head holds the oldest instruction
// FULL  | head and skid both hold instructions

module mw_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int RD_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] tgt,
    input  logic [OP_W-1:0]   op,
    input  logic [RD_W-1:0]   rd,
    input  logic              of,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] target,
    output logic [OP_W-1:0]   opcode,
    output logic [RD_W-1:0]   rd_addr,
    output logic              overflow,
    output logic [1:0]        count
);

    localparam int PW = 3*DATA_W + OP_W + RD_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, skid_q, pay_in, head_vis;
    logic            push, pop;

    assign pay_in = {data, alu, tgt, op, rd, of};
    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        count     = state_q;
    end

    // Payload registers; flush and reset both scrub them so nothing stale can leak out.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            case (state_q)
                EMPTY: if (push) head_q <= pay_in;
                ONE: begin
                    if (push && pop) head_q <= pay_in;
                    else if (push)   skid_q <= pay_in;
                end
                FULL: if (pop) head_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign head_vis = (state_q == EMPTY) ? '0 : head_q;
    assign {data_out, alu_out, target, opcode, rd_addr, overflow} = head_vis;

endmodule

// File: tb/tb_mw_stage.sv
// Self-checking bench for mw_stage: directed scenarios plus random traffic,
// all compared against a queue model of a two-deep in-order buffer.

module tb_mw_stage;

    localparam int DW = 32;
    localparam int OW = 5;
    localparam int RW = 5;
    localparam int PW = 3*DW + OW + RW + 1;

    typedef logic [PW-1:0] pl_t;

    logic          clock = 1'b0;
    logic          reset, in_valid, in_ready, of, flush, out_ready, out_valid, overflow;
    logic [DW-1:0] data, alu, tgt, data_out, alu_out, target;
    logic [OW-1:0] op, opcode;
    logic [RW-1:0] rd, rd_addr;
    logic [1:0]    count;

    always #5 clock = ~clock;

    mw_stage #(.DATA_W(DW), .OP_W(OW), .RD_W(RW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .alu(alu), .tgt(tgt), .op(op), .rd(rd), .of(of),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .data_out(data_out), .alu_out(alu_out), .target(target),
        .opcode(opcode), .rd_addr(rd_addr), .overflow(overflow), .count(count)
    );

    pl_t q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pl_t head_now();
        return {data_out, alu_out, target, opcode, rd_addr, overflow};
    endfunction

    task automatic check_outputs();
        pl_t h;
        h = (q.size() > 0) ? q[0] : '0;
        check_eq("out_valid", 128'(out_valid), 128'(q.size() > 0));
        check_eq("count", 128'(count), 128'(q.size()));
        check_eq("in_ready", 128'(in_ready), 128'(q.size() < 2));
        check_eq("head", 128'(head_now()), 128'(h));
    endtask

    task automatic rand_payload();
        data = $urandom; alu = $urandom; tgt = $urandom;
        op = OW'($urandom); rd = RW'($urandom); of = 1'($urandom);
    endtask

    // Advance one edge: update the queue model with the driven inputs, then check.
    task automatic cycle();
        bit push, pop;
        if (reset || flush) begin
            q.delete();
        end else begin
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({data, alu, tgt, op, rd, of});
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic push_alu(input logic [DW-1:0] a);
        rand_payload();
        in_valid = 1'b1;
        alu = a;
        cycle();
    endtask

    initial begin
        pl_t held;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rand_payload();
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b0;

        // Pass-through
        out_ready = 1'b1;
        rand_payload();
        in_valid = 1'b1; alu = 32'h10; op = 5'd3; rd = 5'd7;
        cycle();
        check_eq("pt_alu", 128'(alu_out), 128'(32'h10));
        check_eq("pt_op", 128'(opcode), 128'(3));
        check_eq("pt_rd", 128'(rd_addr), 128'(7));
        check_eq("pt_count", 128'(count), 128'(1));
        in_valid = 1'b0;
        cycle();

        // Backpressure: A, B fill; C is presented until taken
        out_ready = 1'b0;
        push_alu(32'd1);
        push_alu(32'd2);
        check_eq("bp_count", 128'(count), 128'(2));
        check_eq("bp_in_ready", 128'(in_ready), 128'(0));
        push_alu(32'd3);
        check_eq("bp_hold_A", 128'(alu_out), 128'(1));
        out_ready = 1'b1;
        cycle();
        check_eq("bp_out_B", 128'(alu_out), 128'(2));
        cycle();
        check_eq("bp_out_C", 128'(alu_out), 128'(3));
        in_valid = 1'b0;
        cycle();
        check_eq("bp_drained", 128'(out_valid), 128'(0));

        // Stall stability in FULL with toggling inputs
        out_ready = 1'b0;
        push_alu(32'hA0);
        push_alu(32'hB0);
        held = head_now();
        for (int i = 0; i < 5; i++) begin
            push_alu($urandom);
            check_eq("stall_head", 128'(head_now()), 128'(held));
        end

        // Flush from FULL overrides push and pop
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        check_eq("fl_valid", 128'(out_valid), 128'(0));
        check_eq("fl_count", 128'(count), 128'(0));
        check_eq("fl_head", 128'(head_now()), 128'(0));
        check_eq("fl_in_ready", 128'(in_ready), 128'(1));

        // Reset mid-operation from FULL
        out_ready = 1'b0;
        push_alu(32'h11);
        push_alu(32'h22);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("rst_count", 128'(count), 128'(0));
        check_eq("rst_head", 128'(head_now()), 128'(0));
        out_ready = 1'b1;
        push_alu(32'h55);
        check_eq("rst_next", 128'(alu_out), 128'(32'h55));

        // Streaming with alternating overflow
        for (int i = 0; i < 100; i++) begin
            rand_payload();
            in_valid = 1'b1; alu = DW'(i); of = 1'(i);
            cycle();
            check_eq("st_alu", 128'(alu_out), 128'(i));
            check_eq("st_of", 128'(overflow), 128'(i % 2));
            check_eq("st_count_le1", 128'(count <= 2'd1), 128'(1));
        end
        in_valid = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rand_payload();
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 15) == 0);
            reset     = 1'($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mw_stage.md
MW_STAGE -- requirements
Module: mw_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of data, alu and tgt payload fields.
REQ-002 Parameter OP_W, default 5, SHALL set the opcode field width.
REQ-003 Parameter RD_W, default 5, SHALL set the destination-register field width.
REQ-004 clock  input  1  the single clock, all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream (M stage) presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 data, alu, tgt  input  DATA_W each  memory read data, ALU result, branch/jump target.
REQ-009 op  input  OP_W  opcode.
REQ-010 rd  input  RD_W  destination register address.
REQ-011 of  input  1  ALU overflow flag.
REQ-012 flush  input  1  discard all held and incoming instructions.
REQ-013 out_ready  input  1  W stage consumes head entry this cycle.
REQ-014 out_valid  output  1  head entry valid.
REQ-015 data_out, alu_out, target  output  DATA_W each; opcode  output  OP_W; rd_addr  output  RD_W; overflow  output  1: head entry fields.
REQ-016 count  output  2  occupancy, 0..2.

Function
REQ-017 Block SHALL be a 2-entry in-order skid buffer (head + skid register) carrying the full payload {data, alu, tgt, op, rd, of}.
REQ-018 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 States SHALL be EMPTY (count 0), ONE (count 1), FULL (count 2); out_valid = (state != EMPTY).
REQ-020 in_ready SHALL be (state != FULL), depending on state only, never combinationally on out_ready or in_valid.
REQ-021 EMPTY: push -> ONE, head <= input; else hold.
REQ-022 ONE: push & pop -> ONE, head <= input; push & !pop -> FULL, skid <= input; pop & !push -> EMPTY; neither -> hold.
REQ-023 FULL: pop -> ONE, head <= skid; !pop -> hold; in_valid ignored.
REQ-024 Latency: instruction pushed at edge N SHALL appear on outputs with out_valid=1 after edge N, when state was EMPTY or ONE with a pop at the same edge.
REQ-025 With out_ready held high, throughput SHALL be one instruction per cycle, never entering FULL.
REQ-026 While out_valid=1 and out_ready=0, all head outputs SHALL remain stable.
REQ-027 Instructions SHALL leave in acceptance order; none dropped or duplicated except by flush/reset.
REQ-028 Payload fields SHALL pass through unmodified; no arithmetic on any field.
REQ-029 flush=1 at an edge SHALL force state EMPTY and zero head and skid payloads, overriding any simultaneous push and pop; an instruction presented that cycle is discarded.
REQ-030 Head payload outputs SHALL read as zero whenever state is EMPTY.
REQ-031 count SHALL equal 0, 1, 2 for EMPTY, ONE, FULL.

Reset
REQ-032 reset=1 at an edge SHALL force state EMPTY; zero out_valid, count and all payload outputs; and set in_ready=1 after that edge.
REQ-033 reset SHALL take priority over flush, push and pop, including mid-operation in FULL.
REQ-034 The first edge with reset=0 SHALL behave as normal operation from EMPTY.

Verification
REQ-035 Pass-through: out_ready=1; push alu=0x00000010, op=5'd3, rd=5'd7 -> next cycle out_valid=1, alu_out=0x10, opcode=3, rd_addr=7, count=1.
REQ-036 Backpressure: out_ready=0; push A (alu=1), then B (alu=2) -> count=2, in_ready=0; C (alu=3) is held off; out_ready=1 -> outputs A, B, then C in order, with no loss.
REQ-037 Stall stability: FULL with out_ready=0 for 5 cycles -> head outputs are unchanged every cycle, including when data input toggles.
REQ-038 Flush: FULL, then flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0, all outputs 0, in_ready=1.
REQ-039 Reset mid-operation: count=2, reset=1 for one cycle -> out_valid=0, count=0, payload 0; next push appears normally.
REQ-040 Streaming: 100 back-to-back pushes with out_ready=1 and overflow alternating -> 100 pops in order, count never exceeds 1.
